hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Consumer-side control for the ID/EX pipeline register: reads the ID/EX stage outputs (rd, Reg_write, Mem_read, PC_src) and the decode-stage source registers.
- Drives stall, bubble, flush and freeze enables back into the PC, IF/ID and ID/EX registers.
- Resolves load-use hazards, branch/jump redirects and multi-cycle data-memory stalls through a small FSM.
- Sits beside the ID/EX register; every pipeline-register enable in the core comes from this block.

Parameters:
- FLUSH_CYCLES, 1, number of cycles IF/ID is flushed after a redirect (legal range 1..7).
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-low reset.
- ifid_rs  in  3  source register 1 of the instruction in decode.
- ifid_rt  in  3  source register 2 of the instruction in decode.
- ifid_rs_vld  in  1  ifid_rs is actually read by the decoded instruction.
- ifid_rt_vld  in  1  ifid_rt is actually read by the decoded instruction.
- idex_rd  in  3  destination register held in ID/EX.
- idex_reg_write  in  1  Reg_write held in ID/EX.
- idex_mem_read  in  1  Mem_read held in ID/EX.
- ex_pc_src  in  2  PC_src resolved in EX; 2'b00 means sequential, any other value means redirect taken.
- mem_busy  in  1  data memory not ready; the whole pipeline must hold.
- pc_write  out  1  PC load enable.
- ifid_write  out  1  IF/ID load enable.
- ifid_flush  out  1  load NOP into IF/ID.
- idex_bubble  out  1  zero all control signals entering ID/EX.
- pipe_freeze  out  1  hold every pipeline register, including ID/EX, EX/MEM and MEM/WB.
- stall_cnt  out  CNT_W  saturating count of non-RUN cycles.

Behaviour:
- Outputs are combinational from the state register plus the inputs.
- Reset: while rst is low, force state=RUN, flush_cnt=0, stall_cnt=0, pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1, pipe_freeze=0. Release takes effect on the next clk edge.
- Load-use hit (lu): idex_mem_read & idex_reg_write & ((ifid_rs_vld & ifid_rs==idex_rd) | (ifid_rt_vld & ifid_rt==idex_rd)).
- Redirect (rd_t): ex_pc_src != 2'b00.
- States: RUN, FLUSH, MEM_WAIT. A ret_state register holds RUN or FLUSH for the return from MEM_WAIT.
- RUN, priority 1, mem_busy:
  - pipe_freeze=1, pc_write=0, ifid_write=0, no bubble or flush.
  - ret_state<=RUN; next state MEM_WAIT.
  - The same-cycle rd_t and lu are ignored; both are re-evaluated after the freeze because the registers hold.
- RUN, priority 2, rd_t:
  - pc_write=1, ifid_flush=1, idex_bubble=1.
  - If FLUSH_CYCLES>1: flush_cnt<=FLUSH_CYCLES-1 and next state FLUSH; else stay in RUN.
  - rd_t wins over a same-cycle lu.
- RUN, priority 3, lu:
  - pc_write=0, ifid_write=0, idex_bubble=1 for exactly one cycle.
  - The next cycle ID/EX holds a bubble (Mem_read=0), so lu clears by itself.
- RUN, otherwise: pc_write=1, ifid_write=1, all other outputs 0.
- FLUSH:
  - pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=1.
  - rd_t and lu are ignored (EX holds a bubble).
  - flush_cnt decrements each cycle; when flush_cnt reaches 1, the next state is RUN.
  - If mem_busy: freeze as in RUN, ret_state<=FLUSH, flush_cnt holds.
- MEM_WAIT:
  - pipe_freeze=1, pc_write=0, ifid_write=0.
  - Stay while mem_busy; on the first cycle with mem_busy low, go to ret_state with no outputs asserted in that exit cycle except the freeze release.
- Reset asserted mid-FLUSH or mid-MEM_WAIT: return immediately to RUN; any pending flush count is discarded.

Optional Feature:
- Macro: HAZARD_STALL_CNT_EN.
- Defined: stall_cnt increments on every clk cycle where the state is not RUN, or the state is RUN with a load-use or redirect action. It saturates at all-ones and clears only on reset.
- Undefined: stall_cnt is tied to 0 and no counter flops are built.

Decomposition:
- Shared package hazard_pkg:
  - state encoding constants ST_RUN, ST_FLUSH, ST_MEM_WAIT (2 bits).
  - PC_SRC_SEQ = 2'b00.
  - REG_ADDR_W = 3.
- One natural sub-module, hazard_sat_cnt: generic CNT_W saturating counter with enable and async active-low reset. It is instantiated only under HAZARD_STALL_CNT_EN.

Test Plan:
- Reset: hold rst=0 for 3 cycles with random inputs -> pc_write=0, ifid_flush=1, idex_bubble=1, stall_cnt=0; release rst -> RUN with pc_write=1 on the next cycle.
- Load-use: idex_mem_read=1, idex_reg_write=1, idex_rd=3, ifid_rs=3, ifid_rs_vld=1 -> exactly one cycle with pc_write=0, ifid_write=0, idex_bubble=1. Repeat with ifid_rs_vld=0 -> no stall.
- Redirect with FLUSH_CYCLES=2: ex_pc_src=2'b01 for one cycle -> ifid_flush=1 for 2 consecutive cycles, pc_write=1 in both, then RUN. A simultaneous lu in the first cycle must not stall.
- Memory stall: mem_busy=1 for 4 cycles during RUN with an lu pending -> pipe_freeze=1 for 4 cycles; lu stall occurs in the cycle after the exit cycle; stall_cnt=5 with the macro.
- Freeze inside flush: FLUSH_CYCLES=3, mem_busy=1 for 2 cycles during the second flush cycle -> flush resumes after the freeze; 3 total flush cycles are observed.
- Reset mid-MEM_WAIT: drop rst while mem_busy=1 -> pipe_freeze=0 immediately; after release with mem_busy=0 -> state RUN.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared encodings and helpers for the pipeline hazard controller.
package hazard_pkg;

  localparam int REG_ADDR_W  = 3;
  localparam int FLUSH_CNT_W = 3;

  localparam logic [1:0] PC_SRC_SEQ = 2'b00;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_e;

  // A load in ID/EX whose destination is read by the instruction in decode.
  function automatic logic load_use_hit(
    input logic [REG_ADDR_W-1:0] rs,
    input logic                  rs_vld,
    input logic [REG_ADDR_W-1:0] rt,
    input logic                  rt_vld,
    input logic [REG_ADDR_W-1:0] rd,
    input logic                  mem_read,
    input logic                  reg_write
  );
    return mem_read & reg_write & ((rs_vld & (rs == rd)) | (rt_vld & (rt == rd)));
  endfunction

endpackage

// File: rtl/hazard_sat_cnt.sv
// Generic saturating up-counter with enable; clears only on reset.
module hazard_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en && (cnt_q != {W{1'b1}})) cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, redirect flushes, memory freezes.
// Define HAZARD_STALL_CNT_EN to build the stall performance counter.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] ifid_rs,
  input  logic [REG_ADDR_W-1:0] ifid_rt,
  input  logic                  ifid_rs_vld,
  input  logic                  ifid_rt_vld,
  input  logic [REG_ADDR_W-1:0] idex_rd,
  input  logic                  idex_reg_write,
  input  logic                  idex_mem_read,
  input  logic [1:0]            ex_pc_src,
  input  logic                  mem_busy,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  ifid_flush,
  output logic                  idex_bubble,
  output logic                  pipe_freeze,
  output logic [CNT_W-1:0]      stall_cnt
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_ONE  = FLUSH_CNT_W'(1);
  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

  state_e                  state_q, state_d;
  state_e                  ret_q, ret_d;
  logic [FLUSH_CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic                    lu;
  logic                    rd_t;

  assign lu   = load_use_hit(ifid_rs, ifid_rs_vld, ifid_rt, ifid_rt_vld,
                             idex_rd, idex_mem_read, idex_reg_write);
  assign rd_t = (ex_pc_src != PC_SRC_SEQ);

  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    flush_cnt_d = flush_cnt_q;
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_freeze = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (mem_busy) begin
          // rd_t/lu are re-seen after the freeze because every register holds
          pipe_freeze = 1'b1;
          ret_d       = ST_RUN;
          state_d     = ST_MEM_WAIT;
        end else if (rd_t) begin
          pc_write    = 1'b1;
          ifid_write  = 1'b1;
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            flush_cnt_d = FLUSH_LOAD;
            state_d     = ST_FLUSH;
          end
        end else if (lu) begin
          idex_bubble = 1'b1;
        end else begin
          pc_write    = 1'b1;
          ifid_write  = 1'b1;
        end
      end
      ST_FLUSH: begin
        if (mem_busy) begin
          pipe_freeze = 1'b1;
          ret_d       = ST_FLUSH;
          state_d     = ST_MEM_WAIT;
        end else begin
          pc_write    = 1'b1;
          ifid_write  = 1'b1;
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          flush_cnt_d = flush_cnt_q - FLUSH_ONE;
          if (flush_cnt_q <= FLUSH_ONE) state_d = ST_RUN;
        end
      end
      ST_MEM_WAIT: begin
        // The exit cycle asserts nothing; only the freeze is released.
        if (mem_busy) pipe_freeze = 1'b1;
        else          state_d     = ret_q;
      end
      default: state_d = ST_RUN;
    endcase
    if (!rst) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      pipe_freeze = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_RUN;
      ret_q       <= ST_RUN;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  logic stall_en;
  // Outside RUN every cycle counts; in RUN only a taken redirect or load-use stall.
  assign stall_en = (state_q != ST_RUN) | (~mem_busy & (rd_t | lu));

  hazard_sat_cnt #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst),
    .en    (stall_en),
    .cnt   (stall_cnt)
  );
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: two instances (FLUSH_CYCLES=2 and 3) share inputs.
module tb_hazard_ctrl;
  import hazard_pkg::*;

  localparam int CNT_W = 16;
`ifdef HAZARD_STALL_CNT_EN
  localparam int EXP_MEM_CNT = 5;
`else
  localparam int EXP_MEM_CNT = 0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [2:0]       ifid_rs, ifid_rt, idex_rd;
  logic             ifid_rs_vld, ifid_rt_vld, idex_reg_write, idex_mem_read, mem_busy;
  logic [1:0]       ex_pc_src;
  logic             pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze;
  logic [CNT_W-1:0] stall_cnt;
  logic             pc_write3, ifid_write3, ifid_flush3, idex_bubble3, pipe_freeze3;
  logic [CNT_W-1:0] stall_cnt3;

  logic exp_q[$];
  int   n_total = 0;
  int   n_bad   = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .ifid_rs_vld(ifid_rs_vld), .ifid_rt_vld(ifid_rt_vld), .idex_rd(idex_rd),
    .idex_reg_write(idex_reg_write), .idex_mem_read(idex_mem_read),
    .ex_pc_src(ex_pc_src), .mem_busy(mem_busy), .pc_write(pc_write),
    .ifid_write(ifid_write), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .pipe_freeze(pipe_freeze), .stall_cnt(stall_cnt)
  );

  hazard_ctrl #(.FLUSH_CYCLES(3), .CNT_W(CNT_W)) dut3 (
    .clk(clk), .rst(rst), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .ifid_rs_vld(ifid_rs_vld), .ifid_rt_vld(ifid_rt_vld), .idex_rd(idex_rd),
    .idex_reg_write(idex_reg_write), .idex_mem_read(idex_mem_read),
    .ex_pc_src(ex_pc_src), .mem_busy(mem_busy), .pc_write(pc_write3),
    .ifid_write(ifid_write3), .ifid_flush(ifid_flush3), .idex_bubble(idex_bubble3),
    .pipe_freeze(pipe_freeze3), .stall_cnt(stall_cnt3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int pcw, input int ifw, input int fl,
                         input int bub, input int frz);
    check({tag, ".pc_write"},    32'(pc_write),    pcw);
    check({tag, ".ifid_write"},  32'(ifid_write),  ifw);
    check({tag, ".ifid_flush"},  32'(ifid_flush),  fl);
    check({tag, ".idex_bubble"}, 32'(idex_bubble), bub);
    check({tag, ".pipe_freeze"}, 32'(pipe_freeze), frz);
  endtask

  task automatic chk_out3(input string tag, input int pcw, input int ifw, input int fl,
                          input int bub, input int frz);
    check({tag, ".pc_write3"},    32'(pc_write3),    pcw);
    check({tag, ".ifid_write3"},  32'(ifid_write3),  ifw);
    check({tag, ".ifid_flush3"},  32'(ifid_flush3),  fl);
    check({tag, ".idex_bubble3"}, 32'(idex_bubble3), bub);
    check({tag, ".pipe_freeze3"}, 32'(pipe_freeze3), frz);
  endtask

  // Inputs change 1 time unit after the rising edge; checks sit 2 units later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    ifid_rs = 3'd0; ifid_rt = 3'd0; idex_rd = 3'd0;
    ifid_rs_vld = 1'b0; ifid_rt_vld = 1'b0;
    idex_reg_write = 1'b0; idex_mem_read = 1'b0;
    ex_pc_src = 2'b00; mem_busy = 1'b0;
  endtask

  task automatic set_lu(input logic [2:0] r);
    idex_mem_read = 1'b1; idex_reg_write = 1'b1;
    idex_rd = r; ifid_rs = r; ifid_rs_vld = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ifid_rs        = 3'($urandom_range(0, 7));
      ifid_rt        = 3'($urandom_range(0, 7));
      idex_rd        = 3'($urandom_range(0, 7));
      ifid_rs_vld    = 1'($urandom_range(0, 1));
      ifid_rt_vld    = 1'($urandom_range(0, 1));
      idex_reg_write = 1'($urandom_range(0, 1));
      idex_mem_read  = 1'($urandom_range(0, 1));
      ex_pc_src      = 2'($urandom_range(0, 3));
      mem_busy       = 1'($urandom_range(0, 1));
      #2;
      chk_out("rst", 0, 0, 1, 1, 0);
      check("rst.stall_cnt", 32'(stall_cnt), 0);
      cyc();
    end
    quiet();
    rst = 1'b1;
    cyc();
    #2;
    chk_out("rel", 1, 1, 0, 0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic e;
    int   nflush;
    quiet();
    do_reset();
    chk_out3("rel3", 1, 1, 0, 0, 0);

    // Load-use through rs, then the bubble in ID/EX clears it
    cyc(); set_lu(3'd3); #2; chk_out("lu_rs", 0, 0, 0, 1, 0);
    cyc(); idex_mem_read = 1'b0; #2; chk_out("lu_clear", 1, 1, 0, 0, 0);
    cyc(); set_lu(3'd3); ifid_rs_vld = 1'b0; #2; chk_out("lu_novld", 1, 1, 0, 0, 0);
    cyc(); quiet(); idex_mem_read = 1'b1; idex_reg_write = 1'b1; idex_rd = 3'd5;
    ifid_rt = 3'd5; ifid_rt_vld = 1'b1; #2; chk_out("lu_rt", 0, 0, 0, 1, 0);
    cyc(); idex_reg_write = 1'b0; #2; chk_out("lu_nowr", 1, 1, 0, 0, 0);
    cyc(); quiet(); idex_mem_read = 1'b1; idex_reg_write = 1'b1; idex_rd = 3'd4;
    ifid_rs = 3'd3; ifid_rt = 3'd2; ifid_rs_vld = 1'b1; ifid_rt_vld = 1'b1;
    #2; chk_out("lu_miss", 1, 1, 0, 0, 0);

    // Redirect with a simultaneous load-use: flush two cycles, no stall
    cyc(); quiet(); set_lu(3'd2); ex_pc_src = 2'b01; #2;
    check("rdt.pc_write", 32'(pc_write), 1);
    check("rdt.ifid_flush", 32'(ifid_flush), 1);
    check("rdt.idex_bubble", 32'(idex_bubble), 1);
    check("rdt.pipe_freeze", 32'(pipe_freeze), 0);
    cyc(); ex_pc_src = 2'b00; #2; chk_out("rdt_flush2", 1, 1, 1, 1, 0);
    cyc(); quiet(); #2; chk_out("rdt_done", 1, 1, 0, 0, 0);
    cyc(); ex_pc_src = 2'b11; #2; check("rdt11.ifid_flush", 32'(ifid_flush), 1);
    cyc(); ex_pc_src = 2'b00; #2; check("rdt11.flush2", 32'(ifid_flush), 1);
    cyc(); #2; check("rdt11.done", 32'(ifid_flush), 0);
    cyc(); cyc();

    // Memory stall in RUN with a load-use pending behind it
    do_reset();
    cyc(); set_lu(3'd6); mem_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2; chk_out("mbusy", 0, 0, 0, 0, 1);
      cyc();
    end
    mem_busy = 1'b0; #2; chk_out("mexit", 0, 0, 0, 0, 0);
    cyc(); #2; chk_out("mlu", 0, 0, 0, 1, 0);
    cyc(); idex_mem_read = 1'b0; #2; chk_out("mdone", 1, 1, 0, 0, 0);
    check("mem.stall_cnt", 32'(stall_cnt), EXP_MEM_CNT);

    // Freeze during the second flush cycle of a three-cycle flush
    cyc(); quiet();
    exp_q = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    nflush = 0;
    for (int i = 0; i < 7; i++) begin
      ex_pc_src = (i == 0) ? 2'b01 : 2'b00;
      mem_busy  = (i == 1) || (i == 2);
      #2;
      e = exp_q.pop_front();
      check("ff.ifid_flush3", 32'(ifid_flush3), 32'(e));
      check("ff.pipe_freeze3", 32'(pipe_freeze3), ((i == 1) || (i == 2)) ? 1 : 0);
      if (ifid_flush3) nflush++;
      cyc();
    end
    check("ff.flush_cycles", 32'(nflush), 3);

    // Reset asserted while in MEM_WAIT
    quiet(); mem_busy = 1'b1; #2; chk_out("mw0", 0, 0, 0, 0, 1);
    cyc(); #2; chk_out("mw1", 0, 0, 0, 0, 1);
    #1; rst = 1'b0; #2;
    chk_out("mw_rst", 0, 0, 1, 1, 0);
    check("mw_rst.state", 32'(dut.state_q), 32'(ST_RUN));
    cyc(); mem_busy = 1'b0; rst = 1'b1; #2;
    chk_out("mw_rel", 1, 1, 0, 0, 0);
    check("mw_rel.state", 32'(dut.state_q), 32'(ST_RUN));
    check("mw_rel.stall_cnt", 32'(stall_cnt), 0);

    // Reset asserted mid-flush discards the pending count
    cyc(); ex_pc_src = 2'b10; #2; check("fr.flush_a", 32'(ifid_flush3), 1);
    cyc(); ex_pc_src = 2'b00; #2; check("fr.flush_b", 32'(ifid_flush3), 1);
    #1; rst = 1'b0; #2;
    check("fr_rst.state3", 32'(dut3.state_q), 32'(ST_RUN));
    chk_out3("fr_rst", 0, 0, 1, 1, 0);
    cyc(); rst = 1'b1; #2;
    chk_out3("fr_rel", 1, 1, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
